// File: rtl/hough_pkg.sv
// Shared types for the frame transmitter: FSM encoding, index/pixel widths and stream strobes.
// Pure declarations; no latency or backpressure of its own.
package hough_pkg;

    localparam int PIX_W    = 8;
    localparam int IDX_W    = 8;
    localparam int STROBE_W = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } txState_t;

    typedef logic [STROBE_W-1:0] strobe_t;

    // Sideband travelling alongside a pixel read through the buffer pipeline
    typedef struct packed {
        logic    vld;
        strobe_t frame;
        strobe_t line;
    } pixMeta_t;

    function automatic int bitsFor(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_tx_if.sv
// Buffer-write and pixel-stream signals of frame_tx; slave is the transmitter side.
// No flow control: writes are fire-and-forget, the stream never stalls once started.
interface frame_tx_if;
    import hough_pkg::*;

    logic                WrEn;
    logic [IDX_W-1:0]    WrI;
    logic [IDX_W-1:0]    WrJ;
    logic [PIX_W-1:0]    WrData;
    logic                Start;
    logic                Busy;
    logic [PIX_W-1:0]    Pixel;
    logic [STROBE_W-1:0] Frame;
    logic [STROBE_W-1:0] Line;
    logic                Done;

    modport master (
        output WrEn, WrI, WrJ, WrData, Start,
        input  Busy, Pixel, Frame, Line, Done
    );

    modport slave (
        input  WrEn, WrI, WrJ, WrData, Start,
        output Busy, Pixel, Frame, Line, Done
    );

endinterface

// File: rtl/frame_ram.sv
// Single-write, single-read frame store with a registered read port (1-cycle read latency).
// No backpressure; contents are never reset.
module frame_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          Clk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [DW-1:0] wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [DW-1:0] rdData
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/frame_tx.sv
// Raster-scans a WIDTH x HEIGHT buffer out as a pixel stream with Frame/Line strobes and blanking.
// Pixel (0,0) appears 2 cycles after Start is sampled; free-running, no backpressure.
module frame_tx
    import hough_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int H_BLANK = 4,
    parameter int V_BLANK = 8
) (
    input  logic     Clk,
    input  logic     Reset,
    frame_tx_if.slave bus
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = bitsFor(DEPTH);
    localparam int BLK_W = bitsFor((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);

    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(HEIGHT - 1);
    localparam logic [BLK_W-1:0] H_LAST = BLK_W'(H_BLANK - 1);
    localparam logic [BLK_W-1:0] V_LAST = BLK_W'(V_BLANK - 1);

    txState_t         state;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [BLK_W-1:0] blankCnt;
    pixMeta_t         rdMeta;

    logic             wrEn;
    logic [AW-1:0]    wrAddr;
    logic [AW-1:0]    rdAddr;
    logic [PIX_W-1:0] rdData;

    // Out-of-range coordinates must be dropped, not aliased onto another pixel
    always_comb begin
        wrEn   = bus.WrEn && !bus.Busy && !Reset
              && ({1'b0, bus.WrI} < 9'(WIDTH))
              && ({1'b0, bus.WrJ} < 9'(HEIGHT));
        wrAddr = AW'(32'(bus.WrJ) * 32'(WIDTH) + 32'(bus.WrI));
        rdAddr = AW'(32'(j) * 32'(WIDTH) + 32'(i));
    end

    frame_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (PIX_W)
    ) u_ram (
        .Clk    (Clk),
        .wrEn   (wrEn),
        .wrAddr (wrAddr),
        .wrData (bus.WrData),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            blankCnt  <= '0;
            rdMeta    <= '0;
            bus.Busy  <= 1'b0;
            bus.Done  <= 1'b0;
            bus.Pixel <= '0;
            bus.Frame <= '0;
            bus.Line  <= '0;
        end else begin
            // Strobes ride one stage behind the read address so they land with the RAM data
            rdMeta.vld   <= (state == ACTIVE);
            rdMeta.frame <= strobe_t'(state == ACTIVE && i == '0 && j == '0);
            rdMeta.line  <= strobe_t'(state == ACTIVE && i == '0);

            bus.Pixel <= rdMeta.vld ? rdData : '0;
            bus.Frame <= rdMeta.frame;
            bus.Line  <= rdMeta.line;
            bus.Done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state    <= ACTIVE;
                        bus.Busy <= 1'b1;
                        i        <= '0;
                        j        <= '0;
                    end
                end
                ACTIVE: begin
                    if (i == LAST_I) begin
                        i        <= '0;
                        blankCnt <= '0;
                        state    <= (j == LAST_J) ? VBLANK : HBLANK;
                    end else begin
                        i <= i + IDX_W'(1);
                    end
                end
                HBLANK: begin
                    if (blankCnt == H_LAST) begin
                        state <= ACTIVE;
                        j     <= j + IDX_W'(1);
                    end else begin
                        blankCnt <= blankCnt + BLK_W'(1);
                    end
                end
                VBLANK: begin
                    if (blankCnt == V_LAST) begin
                        state    <= IDLE;
                        j        <= '0;
                        bus.Busy <= 1'b0;
                        bus.Done <= 1'b1;
                    end else begin
                        blankCnt <= blankCnt + BLK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tx.sv
// Self-checking bench for frame_tx: a 16x16 instance and a 1x1 instance against a raster-timing model.
module tb_frame_tx;
    import hough_pkg::*;

    localparam int W  = 16, H  = 16, HB  = 4, VB  = 3 + 5;
    localparam int W1 = 1,  H1 = 1,  HB1 = 4, VB1 = 3;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       frame;
        logic       line;
        logic [7:0] pixel;
    } obs_t;

    typedef struct {
        bit en;
        int x;
        int y;
        int d;
        bit acc;
    } wrVec_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    frame_tx_if bus0 ();
    frame_tx_if bus1 ();

    frame_tx #(.WIDTH(W),  .HEIGHT(H),  .H_BLANK(HB),  .V_BLANK(VB))  dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));
    frame_tx #(.WIDTH(W1), .HEIGHT(H1), .H_BLANK(HB1), .V_BLANK(VB1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

    int checks = 0;
    int errors = 0;
    logic [7:0] ref0 [W*H];
    logic [7:0] ref1 [W1*H1];
    wrVec_t tbl [9];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.busy = bus0.Busy; o.done = bus0.Done; o.frame = bus0.Frame; o.line = bus0.Line; o.pixel = bus0.Pixel;
        end else begin
            o.busy = bus1.Busy; o.done = bus1.Done; o.frame = bus1.Frame; o.line = bus1.Line; o.pixel = bus1.Pixel;
        end
        return o;
    endfunction

    // Expected outputs k cycles after the Start-sampling edge, from raster arithmetic alone
    function automatic obs_t expectAt(input int sel, input int k);
        obs_t e;
        int w, h, hb, vb, f, m, jj, r;
        w  = (sel == 0) ? W  : W1;
        h  = (sel == 0) ? H  : H1;
        hb = (sel == 0) ? HB : HB1;
        vb = (sel == 0) ? VB : VB1;
        f  = h * w + (h - 1) * hb + vb;
        e  = '0;
        e.busy = (k < f);
        e.done = (k == f);
        m = k - 2;
        if (m >= 0) begin
            jj = m / (w + hb);
            r  = m % (w + hb);
            if (jj < h && r < w) begin
                e.pixel = (sel == 0) ? ref0[jj * w + r] : ref1[jj * w + r];
                e.line  = (r == 0);
                e.frame = (r == 0 && jj == 0);
            end
        end
        return e;
    endfunction

    function automatic int frameLen(input int sel);
        return (sel == 0) ? (H * W + (H - 1) * HB + VB) : (H1 * W1 + (H1 - 1) * HB1 + VB1);
    endfunction

    task automatic check(input string name, input int k, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got busy=%0b done=%0b frame=%0b line=%0b pixel=%02h expected busy=%0b done=%0b frame=%0b line=%0b pixel=%02h",
                     name, k, got.busy, got.done, got.frame, got.line, got.pixel,
                     exp.busy, exp.done, exp.frame, exp.line, exp.pixel);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic setWr(input int sel, input bit en, input int x, input int y, input int d);
        if (sel == 0) begin
            bus0.WrEn = en; bus0.WrI = 8'(x); bus0.WrJ = 8'(y); bus0.WrData = 8'(d);
        end else begin
            bus1.WrEn = en; bus1.WrI = 8'(x); bus1.WrJ = 8'(y); bus1.WrData = 8'(d);
        end
    endtask

    task automatic setStart(input int sel, input bit v);
        if (sel == 0) bus0.Start = v;
        else          bus1.Start = v;
    endtask

    // Idle-time write; acc says whether the reference buffer takes the value
    task automatic doWrite(input int sel, input bit en, input int x, input int y, input int d, input bit acc);
        setWr(sel, en, x, y, d);
        tick;
        setWr(sel, 1'b0, 0, 0, 0);
        if (acc) begin
            if (sel == 0) ref0[y * W + x] = 8'(d);
            else          ref1[y * W1 + x] = 8'(d);
        end
    endtask

    task automatic runFrame(input int sel, input bit keepStart, input bit busyWr, input string name,
                            output int lines, output int frames);
        obs_t got;
        int   f;
        f = frameLen(sel);
        lines  = 0;
        frames = 0;
        setStart(sel, 1'b1);
        tick;
        if (!keepStart) setStart(sel, 1'b0);
        for (int k = 0; k <= f; k++) begin
            if (k > 0) begin
                if (busyWr) setWr(sel, 1'b1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom);
                tick;
            end
            got = sample(sel);
            check(name, k, got, expectAt(sel, k));
            lines  += int'(got.line);
            frames += int'(got.frame);
        end
        setWr(sel, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int   ln, fr, kStop, x, y;
        bit   en;
        obs_t got;

        tbl = '{
            '{1'b1,   3,   2, 8'h11, 1'b1},
            '{1'b1,  16,   2, 8'h22, 1'b0},
            '{1'b1,   0,  16, 8'h33, 1'b0},
            '{1'b0,   5,   5, 8'h44, 1'b0},
            '{1'b1,  15,  15, 8'h55, 1'b1},
            '{1'b1, 255,   0, 8'h66, 1'b0},
            '{1'b1,   0,   0, 8'h77, 1'b1},
            '{1'b1,  15,   0, 8'h88, 1'b1},
            '{1'b1, 255, 255, 8'h99, 1'b0}
        };

        Reset = 1'b1;
        setWr(0, 1'b0, 0, 0, 0);
        setWr(1, 1'b0, 0, 0, 0);
        setStart(0, 1'b0);
        setStart(1, 1'b0);
        repeat (3) tick;
        check("reset_dut0", 0, sample(0), '0);
        check("reset_dut1", 0, sample(1), '0);
        Reset = 1'b0;

        // Raster pattern: pixel stream must count 0x00..0xFF
        for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++)
                doWrite(0, 1'b1, i, j, (j * 16 + i) & 8'hFF, 1'b1);
        runFrame(0, 1'b0, 1'b0, "pattern", ln, fr);
        checkInt("pattern_lines", ln, H);
        checkInt("pattern_frames", fr, 1);

        // Write-gating table, then writes attempted while Busy must be ignored
        for (int t = 0; t < 9; t++)
            doWrite(0, tbl[t].en, tbl[t].x, tbl[t].y, tbl[t].d, tbl[t].acc);
        runFrame(0, 1'b0, 1'b1, "table_busywr", ln, fr);
        runFrame(0, 1'b0, 1'b0, "after_busywr", ln, fr);

        // Random idle writes with some coordinates out of range
        for (int t = 0; t < 40; t++) begin
            x  = $urandom_range(0, 19);
            y  = $urandom_range(0, 19);
            en = 1'($urandom_range(0, 1));
            doWrite(0, en, x, y, $urandom, en && x < W && y < H);
        end
        runFrame(0, 1'b0, 1'b0, "random", ln, fr);

        // Reset in the middle of line 5
        kStop = 2 + 5 * (W + HB) + 7;
        setStart(0, 1'b1);
        tick;
        setStart(0, 1'b0);
        for (int k = 0; k <= kStop; k++) begin
            if (k > 0) tick;
            check("pre_reset", k, sample(0), expectAt(0, k));
        end
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        check("midreset_out", 0, sample(0), '0);
        tick;
        check("midreset_idle", 1, sample(0), '0);
        runFrame(0, 1'b0, 1'b0, "post_reset", ln, fr);
        checkInt("post_reset_lines", ln, H);

        // Start held high: frames run back to back
        runFrame(0, 1'b1, 1'b0, "held1", ln, fr);
        runFrame(0, 1'b1, 1'b0, "held2", ln, fr);
        runFrame(0, 1'b0, 1'b0, "held3", ln, fr);
        tick;
        got = sample(0);
        check("held_stop", 0, got, '0);

        // Single-pixel instance
        doWrite(1, 1'b1, 0, 0, 8'hA5, 1'b1);
        doWrite(1, 1'b1, 1, 0, 8'h5A, 1'b0);
        doWrite(1, 1'b1, 0, 1, 8'h3C, 1'b0);
        runFrame(1, 1'b0, 1'b0, "one_pixel", ln, fr);
        checkInt("one_pixel_lines", ln, 1);
        checkInt("one_pixel_frames", fr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
